// File: rtl/aemb2_xwbarb.sv
// Two-master Wishbone arbiter: shares one external bus between instruction fetch (read-only)
// and data (read/write) masters, alternating priority and aborting stalled cycles on timeout.
module aemb2_xwbarb #(
    parameter int AEMB_XWB = 32,
    parameter int AEMB_TMO = 8
) (
    input  logic                  gclk,
    input  logic                  grst,

    input  logic                  iwb_stb_i,
    input  logic [AEMB_XWB-1:2]   iwb_adr_i,
    output logic                  iwb_ack_o,
    output logic                  iwb_err_o,
    output logic [31:0]           iwb_dat_o,

    input  logic                  dwb_stb_i,
    input  logic                  dwb_wre_i,
    input  logic [3:0]            dwb_sel_i,
    input  logic [AEMB_XWB-1:2]   dwb_adr_i,
    input  logic [31:0]           dwb_dat_i,
    output logic                  dwb_ack_o,
    output logic                  dwb_err_o,
    output logic [31:0]           dwb_dat_o,

    output logic                  xwb_cyc_o,
    output logic                  xwb_stb_o,
    output logic                  xwb_wre_o,
    output logic [3:0]            xwb_sel_o,
    output logic [AEMB_XWB-1:2]   xwb_adr_o,
    output logic [31:0]           xwb_dat_o,
    output logic                  xwb_tag_o,
    input  logic                  xwb_ack_i,
    input  logic [31:0]           xwb_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic                LAST_I  = 1'b1;
    localparam logic                LAST_D  = 1'b0;
    localparam logic [AEMB_TMO-1:0] TMO_MAX = '1;
    localparam logic [AEMB_TMO-1:0] TMO_ONE = {{(AEMB_TMO-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   last_q,  last_d;
    logic [AEMB_TMO-1:0]    tmo_q,   tmo_d;
    logic                   cyc_q,   cyc_d;
    logic                   wre_q,   wre_d;
    logic                   tag_q,   tag_d;
    logic [3:0]             sel_q,   sel_d;
    logic [AEMB_XWB-1:2]    adr_q,   adr_d;
    logic [31:0]            dat_q,   dat_d;

    logic                   owner_stb;
    logic                   tmo_full;

    assign owner_stb = (state_q == IGNT) ? iwb_stb_i : dwb_stb_i;
    // tmo_q counts the unacked grant cycles already elapsed, so the current cycle is tmo_q+1.
    assign tmo_full  = ((tmo_q + TMO_ONE) == TMO_MAX);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q;
        wre_d   = wre_q;
        tag_d   = tag_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                if (dwb_stb_i && (!iwb_stb_i || last_q == LAST_I)) begin
                    state_d = DGNT;
                    last_d  = LAST_D;
                    tmo_d   = '0;
                    cyc_d   = 1'b1;
                    tag_d   = 1'b0;
                    wre_d   = dwb_wre_i;
                    sel_d   = dwb_sel_i;
                    adr_d   = dwb_adr_i;
                    dat_d   = dwb_dat_i;
                end else if (iwb_stb_i) begin
                    state_d = IGNT;
                    last_d  = LAST_I;
                    tmo_d   = '0;
                    cyc_d   = 1'b1;
                    tag_d   = 1'b1;
                    wre_d   = 1'b0;
                    sel_d   = 4'hF;
                    adr_d   = iwb_adr_i;
                end
            end
            IGNT, DGNT: begin
                // Ack, owner withdrawal and timeout all end the cycle the same way.
                if (xwb_ack_i || !owner_stb || tmo_full) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end else begin
                    tmo_d   = tmo_q + TMO_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            last_q  <= LAST_I;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            wre_q   <= 1'b0;
            tag_q   <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            wre_q   <= wre_d;
            tag_q   <= tag_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign xwb_cyc_o = cyc_q;
    assign xwb_stb_o = cyc_q;
    assign xwb_wre_o = wre_q;
    assign xwb_tag_o = tag_q;
    assign xwb_sel_o = sel_q;
    assign xwb_adr_o = adr_q;
    assign xwb_dat_o = dat_q;

    assign iwb_ack_o = (state_q == IGNT) && xwb_ack_i;
    assign dwb_ack_o = (state_q == DGNT) && xwb_ack_i;
    // A withdrawn request is an abort, not a timeout, so err also needs the owner's stb.
    assign iwb_err_o = (state_q == IGNT) && iwb_stb_i && !xwb_ack_i && tmo_full;
    assign dwb_err_o = (state_q == DGNT) && dwb_stb_i && !xwb_ack_i && tmo_full;

    assign iwb_dat_o = xwb_dat_i;
    assign dwb_dat_o = xwb_dat_i;

endmodule
